// File: rtl/accel_pkg.sv
// Shared constants, mode encoding and the round/saturate helper used by the
// conv and fc datapaths of the LeNet-5 accelerator.
package accel_pkg;

  localparam int DWIDTH    = 16;
  localparam int QWIDTH    = 11;
  localparam int N_LANES   = 16;
  localparam int ACC_GUARD = 8;
  localparam int ACC_W     = 2 * DWIDTH + ACC_GUARD;
  localparam int RS_W      = 64;

  typedef enum logic {
    MODE_CONV = 1'b0,
    MODE_FC   = 1'b1
  } mode_e;

  typedef struct packed {
    logic                   sat;
    logic signed [RS_W-1:0] val;
  } rs_t;

  // Round half up by qw fractional bits, then clamp to a dw-bit signed range.
  function automatic rs_t round_sat(input logic signed [RS_W-1:0] v,
                                    input int qw, input int dw);
    logic signed [RS_W-1:0] half;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    rs_t                    res;
    half = 64'sd1 <<< (qw - 1);
    r    = (v + half) >>> qw;
    hi   = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo   = -(64'sd1 <<< (dw - 1));
    if (r > hi) begin
      res.sat = 1'b1;
      res.val = hi;
    end else if (r < lo) begin
      res.sat = 1'b1;
      res.val = lo;
    end else begin
      res.sat = 1'b0;
      res.val = r;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed fixed-point lane: S2 product register, S3 accumulate or
// round/saturate into the lane's output register.
module mac_lane #(
  parameter int DWIDTH    = accel_pkg::DWIDTH,
  parameter int QWIDTH    = accel_pkg::QWIDTH,
  parameter int ACC_GUARD = accel_pkg::ACC_GUARD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     s1_valid,
  input  logic                     s2_valid,
  input  logic                     s2_mode,
  input  logic                     s2_last,
  input  logic signed [DWIDTH-1:0] din,
  input  logic signed [DWIDTH-1:0] win,
  output logic        [DWIDTH-1:0] dout,
  output logic                     sat
);
  import accel_pkg::*;

  localparam int PW   = 2 * DWIDTH;
  localparam int AW   = 2 * DWIDTH + ACC_GUARD;

  logic signed [PW-1:0] p_q, p_d;
  logic signed [AW-1:0] acc_q, acc_d, sum_s;
  logic [DWIDTH-1:0]    dout_q, dout_d;
  logic                 sat_q, sat_d;
  logic                 emit_s;
  rs_t                  rs_s;
  logic                 unused_s;

  assign unused_s = ^rs_s.val[RS_W-1:DWIDTH];

  always_comb begin
    emit_s = s2_valid && (!s2_mode || s2_last);
    sum_s  = acc_q + AW'(p_q);
    rs_s   = round_sat(s2_mode ? RS_W'(sum_s) : RS_W'(p_q), QWIDTH, DWIDTH);

    if (!stall && s1_valid) begin
      p_d = din * win;
    end else begin
      p_d = p_q;
    end

    // The closing beat clears the accumulator so the next group starts at once.
    if (!stall && s2_valid && s2_mode) begin
      acc_d = s2_last ? {AW{1'b0}} : sum_s;
    end else begin
      acc_d = acc_q;
    end

    if (!stall && emit_s) begin
      dout_d = rs_s.val[DWIDTH-1:0];
      sat_d  = rs_s.sat;
    end else begin
      dout_d = dout_q;
      sat_d  = sat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= {PW{1'b0}};
      acc_q  <= {AW{1'b0}};
      dout_q <= {DWIDTH{1'b0}};
      sat_q  <= 1'b0;
    end else begin
      p_q    <= p_d;
      acc_q  <= acc_d;
      dout_q <= dout_d;
      sat_q  <= sat_d;
    end
  end

  assign dout = dout_q;
  assign sat  = sat_q;

endmodule

// File: rtl/mac_lane_array.sv
// N_LANES signed MAC lanes behind one shared valid/ready pipeline; the
// operand stage and all flow control live here, the arithmetic in mac_lane.
module mac_lane_array #(
  parameter int DWIDTH    = 16,
  parameter int QWIDTH    = 11,
  parameter int N_LANES   = 16,
  parameter int ACC_GUARD = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [N_LANES*DWIDTH-1:0] din,
  input  logic [N_LANES*DWIDTH-1:0] win,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_LANES*DWIDTH-1:0] dout,
  output logic [N_LANES-1:0]        out_sat,
  output logic                      idle
);
  import accel_pkg::*;

  localparam int BW = N_LANES * DWIDTH;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_mode_q, s1_mode_d;
  logic          s1_last_q, s1_last_d;
  logic [BW-1:0] s1_din_q, s1_din_d;
  logic [BW-1:0] s1_win_q, s1_win_d;
  logic          s2_valid_q, s2_valid_d;
  logic          s2_mode_q, s2_mode_d;
  logic          s2_last_q, s2_last_d;
  logic          out_valid_q, out_valid_d;
  logic          open_q, open_d;
  logic          stall_s, accept_s;

  assign stall_s  = out_valid_q && !out_ready;
  assign accept_s = in_valid && !stall_s;

  always_comb begin
    if (!stall_s) begin
      s1_valid_d  = accept_s;
      s1_mode_d   = mode;
      s1_last_d   = in_last && (mode == MODE_FC);
      s2_valid_d  = s1_valid_q;
      s2_mode_d   = s1_mode_q;
      s2_last_d   = s1_last_q;
      out_valid_d = s2_valid_q && ((s2_mode_q == MODE_CONV) || s2_last_q);
    end else begin
      s1_valid_d  = s1_valid_q;
      s1_mode_d   = s1_mode_q;
      s1_last_d   = s1_last_q;
      s2_valid_d  = s2_valid_q;
      s2_mode_d   = s2_mode_q;
      s2_last_d   = s2_last_q;
      out_valid_d = out_valid_q;
    end

    if (accept_s) begin
      s1_din_d = din;
      s1_win_d = win;
    end else begin
      s1_din_d = s1_din_q;
      s1_win_d = s1_win_q;
    end

    // A group is open from its first fc beat until its closing beat is taken.
    if (accept_s && (mode == MODE_FC)) begin
      open_d = !in_last;
    end else begin
      open_d = open_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_din_q    <= {BW{1'b0}};
      s1_win_q    <= {BW{1'b0}};
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      open_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_last_q   <= s1_last_d;
      s1_din_q    <= s1_din_d;
      s1_win_q    <= s1_win_d;
      s2_valid_q  <= s2_valid_d;
      s2_mode_q   <= s2_mode_d;
      s2_last_q   <= s2_last_d;
      out_valid_q <= out_valid_d;
      open_q      <= open_d;
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    mac_lane #(
      .DWIDTH   (DWIDTH),
      .QWIDTH   (QWIDTH),
      .ACC_GUARD(ACC_GUARD)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .stall   (stall_s),
      .s1_valid(s1_valid_q),
      .s2_valid(s2_valid_q),
      .s2_mode (s2_mode_q),
      .s2_last (s2_last_q),
      .din     (s1_din_q[i*DWIDTH +: DWIDTH]),
      .win     (s1_win_q[i*DWIDTH +: DWIDTH]),
      .dout    (dout[i*DWIDTH +: DWIDTH]),
      .sat     (out_sat[i])
    );
  end

  assign in_ready  = !stall_s;
  assign out_valid = out_valid_q;
  assign idle      = !s1_valid_q && !s2_valid_q && !out_valid_q && !open_q;

endmodule

// File: tb/tb_mac_lane_array.sv
// Directed self-checking bench for mac_lane_array (DWIDTH=16, QWIDTH=11, 16 lanes).
module tb_mac_lane_array;
  localparam int DW = 16;
  localparam int NL = 16;

  logic             clk = 1'b0;
  logic             rst, mode, in_valid, in_last, out_ready;
  logic [NL*DW-1:0] din, win;
  logic             in_ready, out_valid, idle;
  logic [NL*DW-1:0] dout;
  logic [NL-1:0]    out_sat;

  int checks = 0;
  int errors = 0;

  mac_lane_array #(.DWIDTH(16), .QWIDTH(11), .N_LANES(16), .ACC_GUARD(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .din(din), .win(win), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .out_sat(out_sat), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic signed [15:0] d, input logic signed [15:0] w);
    for (int i = 0; i < NL; i++) begin
      din[i*DW +: DW] = d;
      win[i*DW +: DW] = w;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    set_all(16'sd0, 16'sd0);
    tick; tick;
    rst = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (dout !== {NL*DW{1'b0}}) begin errors++; $display("FAIL reset_dout got=%h exp=0", dout); end
    checks++; if (out_sat !== {NL{1'b0}}) begin errors++; $display("FAIL reset_out_sat got=%h exp=0", out_sat); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", idle); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_conv_basic;
    logic [NL*DW-1:0] exp_d;
    exp_d = {NL{16'sd3072}};
    mode = 1'b0;
    set_all(16'sd3072, 16'sd2048);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL conv_lat1 got=%b exp=0", out_valid); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL conv_lat2 got=%b exp=0", out_valid); end
    tick;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL conv_lat3 got=%b exp=1", out_valid); end
    checks++; if (dout !== exp_d) begin errors++; $display("FAIL conv_dout got=%h exp=%h", dout, exp_d); end
    checks++; if (out_sat !== {NL{1'b0}}) begin errors++; $display("FAIL conv_sat got=%h exp=0", out_sat); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL conv_single got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturate;
    logic [NL*DW-1:0] exp_d;
    set_all(16'sd32767, 16'sd32767);
    in_valid = 1'b1;
    tick;
    set_all(-16'sd32768, 16'sd32767);
    tick;
    in_valid = 1'b0;
    tick;
    exp_d = {NL{16'sd32767}};
    checks++; if (out_valid !== 1'b1 || dout !== exp_d) begin errors++; $display("FAIL sat_pos got=%b/%h exp=1/%h", out_valid, dout, exp_d); end
    checks++; if (out_sat !== {NL{1'b1}}) begin errors++; $display("FAIL sat_pos_flag got=%h exp=ffff", out_sat); end
    tick;
    exp_d = {NL{16'h8000}};
    checks++; if (out_valid !== 1'b1 || dout !== exp_d) begin errors++; $display("FAIL sat_neg got=%b/%h exp=1/%h", out_valid, dout, exp_d); end
    checks++; if (out_sat !== {NL{1'b1}}) begin errors++; $display("FAIL sat_neg_flag got=%h exp=ffff", out_sat); end
    tick;
  endtask

  task automatic test_lanes;
    logic [NL*DW-1:0] exp_d;
    for (int i = 0; i < NL; i++) begin
      case (i % 4)
        0:       begin din[i*DW +: DW] = 16'sd1;     win[i*DW +: DW] = 16'sd1024; exp_d[i*DW +: DW] = 16'sd1;     end
        1:       begin din[i*DW +: DW] = -16'sd1;    win[i*DW +: DW] = 16'sd1024; exp_d[i*DW +: DW] = 16'sd0;     end
        2:       begin din[i*DW +: DW] = -16'sd3;    win[i*DW +: DW] = 16'sd1024; exp_d[i*DW +: DW] = -16'sd1;    end
        default: begin din[i*DW +: DW] = -16'sd3072; win[i*DW +: DW] = 16'sd2048; exp_d[i*DW +: DW] = -16'sd3072; end
      endcase
    end
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick;
    checks++; if (out_valid !== 1'b1 || dout !== exp_d) begin errors++; $display("FAIL lanes_round got=%b/%h exp=1/%h", out_valid, dout, exp_d); end
    checks++; if (out_sat !== {NL{1'b0}}) begin errors++; $display("FAIL lanes_sat got=%h exp=0", out_sat); end
    tick;
  endtask

  task automatic test_stall;
    int sent = 0;
    int recv = 0;
    int stall_cycles = 0;
    logic prev_stall = 1'b0;
    logic acc;
    logic [NL*DW-1:0] prev_d;
    logic [NL*DW-1:0] exp_d;
    prev_d = dout;
    mode = 1'b0;
    for (int t = 0; t < 40 && recv < 10; t++) begin
      out_ready = !(t >= 5 && t <= 8);
      in_valid  = (sent < 10);
      set_all(16'(sent * 100 + 5), 16'sd2048);
      #1;
      if (out_valid && !out_ready) stall_cycles++;
      checks++; if (in_ready !== !(out_valid && !out_ready)) begin errors++; $display("FAIL stall_in_ready t=%0d got=%b exp=%b", t, in_ready, !(out_valid && !out_ready)); end
      if (prev_stall) begin
        checks++; if (dout !== prev_d) begin errors++; $display("FAIL stall_hold t=%0d got=%h exp=%h", t, dout, prev_d); end
      end
      if (out_valid && out_ready) begin
        exp_d = {NL{16'(recv * 100 + 5)}};
        checks++; if (dout !== exp_d) begin errors++; $display("FAIL stall_order r=%0d got=%h exp=%h", recv, dout, exp_d); end
        recv++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = dout;
      acc = in_valid && in_ready;
      tick;
      if (acc) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (recv != 10) begin errors++; $display("FAIL stall_count got=%0d exp=10", recv); end
    checks++; if (stall_cycles != 4) begin errors++; $display("FAIL stall_cycles got=%0d exp=4", stall_cycles); end
    tick; tick;
    checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL stall_drain got=%b/%b exp=0/1", out_valid, idle); end
  endtask

  task automatic test_fc_group;
    logic [NL*DW-1:0] exp_d;
    exp_d = {NL{16'sd4096}};
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL fc_mode_change_idle got=%b exp=1", idle); end
    mode = 1'b1;
    for (int b = 0; b < 4; b++) begin
      set_all(16'sd2048, 16'sd1024);
      in_last = (b == 3);
      in_valid = 1'b1;
      tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fc_early b=%0d got=%b exp=0", b, out_valid); end
      if (b == 0) begin
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL fc_open_idle got=%b exp=0", idle); end
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fc_lat2 got=%b exp=0", out_valid); end
    tick;
    checks++; if (out_valid !== 1'b1 || dout !== exp_d) begin errors++; $display("FAIL fc_sum got=%b/%h exp=1/%h", out_valid, dout, exp_d); end
    checks++; if (out_sat !== {NL{1'b0}}) begin errors++; $display("FAIL fc_sat got=%h exp=0", out_sat); end
    tick;
    checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL fc_after got=%b/%b exp=0/1", out_valid, idle); end
  endtask

  task automatic test_back_to_back;
    logic signed [15:0] bd [5];
    logic signed [15:0] bw [5];
    logic               bl [5];
    logic [NL*DW-1:0]   exp_d;
    int nres = 0;
    bd = '{16'sd2048, 16'sd2048, 16'sd2048, 16'sd2048, 16'sd2048};
    bw = '{16'sd2048, 16'sd1024, 16'sd2048, 16'sd2048, 16'sd2048};
    bl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL b2b_start_idle got=%b exp=1", idle); end
    mode = 1'b1;
    for (int t = 0; t < 12; t++) begin
      if (t < 5) begin
        set_all(bd[t], bw[t]);
        in_last = bl[t];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
        in_last = 1'b0;
      end
      #1;
      if (out_valid) begin
        nres++;
        exp_d = (nres == 1) ? {NL{16'sd3072}} : {NL{16'sd6144}};
        checks++; if (dout !== exp_d) begin errors++; $display("FAIL b2b_sum n=%0d got=%h exp=%h", nres, dout, exp_d); end
        checks++; if (t != ((nres == 1) ? 4 : 7)) begin errors++; $display("FAIL b2b_time n=%0d got=%0d exp=%0d", nres, t, (nres == 1) ? 4 : 7); end
      end
      tick;
    end
    checks++; if (nres != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", nres); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL b2b_idle got=%b exp=1", idle); end
  endtask

  task automatic test_reset_mid;
    logic [NL*DW-1:0] exp_d;
    exp_d = {NL{16'sd1024}};
    mode = 1'b1;
    set_all(16'sd32767, 16'sd32767);
    in_last = 1'b0;
    in_valid = 1'b1;
    tick; tick;
    in_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || dout !== {NL*DW{1'b0}} || idle !== 1'b1) begin errors++; $display("FAIL rstmid_clear got=%b/%h/%b exp=0/0/1", out_valid, dout, idle); end
    set_all(16'sd1024, 16'sd2048);
    in_last = 1'b1;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0; in_last = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early got=%b exp=0", out_valid); end
    tick;
    checks++; if (out_valid !== 1'b1 || dout !== exp_d) begin errors++; $display("FAIL rstmid_sum got=%b/%h exp=1/%h", out_valid, dout, exp_d); end
    checks++; if (out_sat !== {NL{1'b0}}) begin errors++; $display("FAIL rstmid_sat got=%h exp=0", out_sat); end
    tick;
  endtask

  initial begin
    test_reset;
    test_conv_basic;
    test_saturate;
    test_lanes;
    test_stall;
    test_fc_group;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
